// File: rtl/regfile_wr_arbiter.sv
// Shares the register-file write port between requester A (older, load) and B (younger, ALU); optional stall via WR_ARB_STALL_EN.
// Latency: ready is combinational; we/wdata/pc_write/conflict are registered, one cycle after the grant.
// Backpressure: a requester not granted (or both, while stalled) sees ready low and holds valid/addr/data.
module regfile_wr_arbiter #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef WR_ARB_STALL_EN
    input  logic              stall,
`endif
    input  logic              a_valid,
    input  logic [3:0]        a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_ready,
    input  logic              b_valid,
    input  logic [3:0]        b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    output logic [15:0]       we,
    output logic [DATA_W-1:0] wdata,
    output logic              pc_write,
    output logic              conflict
);

    typedef enum logic {
        PRI_A = 1'b0,
        PRI_B = 1'b1
    } pri_t;

    pri_t              pri_q;
    pri_t              pri_d;
    logic              hold;
    logic              both_vld;
    logic              same_addr;
    logic              grant_a;
    logic              grant_b;
    logic              grant_any;
    logic [3:0]        win_addr;
    logic [DATA_W-1:0] win_data;
    logic [15:0]       we_d;

`ifdef WR_ARB_STALL_EN
    assign hold = stall;
`else
    assign hold = 1'b0;
`endif

    assign both_vld  = a_valid & b_valid;
    assign same_addr = both_vld & (a_addr == b_addr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pri_q <= PRI_A;
        end else begin
            pri_q <= pri_d;
        end
    end

    // Readies are gated by reset_n so nothing is granted while reset is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        pri_d   = pri_q;
        if (reset_n && !hold) begin
            if (both_vld) begin
                if (same_addr) begin
                    // Older write goes first so the younger one lands last.
                    grant_a = 1'b1;
                end else if (pri_q == PRI_A) begin
                    grant_a = 1'b1;
                    pri_d   = PRI_B;
                end else begin
                    grant_b = 1'b1;
                    pri_d   = PRI_A;
                end
            end else if (a_valid) begin
                grant_a = 1'b1;
            end else if (b_valid) begin
                grant_b = 1'b1;
            end
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign grant_any = grant_a | grant_b;
    assign win_addr  = grant_b ? b_addr : a_addr;
    assign win_data  = grant_b ? b_data : a_data;
    assign we_d      = grant_any ? (16'h0001 << win_addr) : 16'h0000;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            we       <= 16'h0000;
            wdata    <= '0;
            pc_write <= 1'b0;
            conflict <= 1'b0;
        end else begin
            we       <= we_d;
            pc_write <= (we_d == 16'h8000);
            conflict <= both_vld;
            if (grant_any) begin
                wdata <= win_data;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter: a priority/ordering model checked every cycle plus literal expectations.
module tb_regfile_wr_arbiter;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              stall = 1'b0;
    logic              a_valid = 1'b0;
    logic [3:0]        a_addr = '0;
    logic [DATA_W-1:0] a_data = '0;
    logic              a_ready;
    logic              b_valid = 1'b0;
    logic [3:0]        b_addr = '0;
    logic [DATA_W-1:0] b_data = '0;
    logic              b_ready;
    logic [15:0]       we;
    logic [DATA_W-1:0] wdata;
    logic              pc_write;
    logic              conflict;
    logic              stall_eff;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_wr_arbiter #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
`ifdef WR_ARB_STALL_EN
        .stall    (stall),
`endif
        .a_valid  (a_valid),
        .a_addr   (a_addr),
        .a_data   (a_data),
        .a_ready  (a_ready),
        .b_valid  (b_valid),
        .b_addr   (b_addr),
        .b_data   (b_data),
        .b_ready  (b_ready),
        .we       (we),
        .wdata    (wdata),
        .pc_write (pc_write),
        .conflict (conflict)
    );

`ifdef WR_ARB_STALL_EN
    assign stall_eff = stall;
`else
    assign stall_eff = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: 0 = no grant, 1 = A, 2 = B.
    function automatic int pick(bit rst_ok, bit stl, bit av, bit bv,
                                logic [3:0] aa, logic [3:0] ba, bit favour_b);
        if (!rst_ok || stl) return 0;
        if (av && bv) begin
            if (aa == ba) return 1;
            return favour_b ? 2 : 1;
        end
        if (av) return 1;
        if (bv) return 2;
        return 0;
    endfunction

    bit                m_favour_b = 1'b0;
    logic [15:0]       m_we       = '0;
    logic [DATA_W-1:0] m_wdata    = '0;
    bit                m_pc       = 1'b0;
    bit                m_conf     = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        int         w;
        logic [3:0] addr;
        if (!reset_n) begin
            m_favour_b = 1'b0;
            m_we       = '0;
            m_wdata    = '0;
            m_pc       = 1'b0;
            m_conf     = 1'b0;
        end else begin
            w      = pick(1'b1, stall_eff, a_valid, b_valid, a_addr, b_addr, m_favour_b);
            addr   = (w == 2) ? b_addr : a_addr;
            m_conf = a_valid & b_valid;
            if (w == 0) begin
                m_we = '0;
                m_pc = 1'b0;
            end else begin
                m_we    = 16'(2 ** int'(addr));
                m_wdata = (w == 2) ? b_data : a_data;
                m_pc    = (addr == 4'd15);
            end
            if (w != 0 && a_valid && b_valid && a_addr != b_addr) m_favour_b = !m_favour_b;
        end
    end

    always @(negedge clk) begin
        int w;
        w = pick(reset_n, stall_eff, a_valid, b_valid, a_addr, b_addr, m_favour_b);
        check("m_a_ready", a_ready, (w == 1));
        check("m_b_ready", b_ready, (w == 2));
        check("m_we", we, m_we);
        check("m_pc_write", pc_write, m_pc);
        check("m_conflict", conflict, m_conf);
        if (m_we != 0) check("m_wdata", wdata, m_wdata);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input logic v, input logic [3:0] ad, input logic [DATA_W-1:0] d);
        a_valid = v; a_addr = ad; a_data = d;
    endtask

    task automatic set_b(input logic v, input logic [3:0] ad, input logic [DATA_W-1:0] d);
        b_valid = v; b_addr = ad; b_data = d;
    endtask

    logic [15:0] rr_we [3];
    logic [3:0]  ta_addr [6];
    logic [3:0]  tb_addr [6];
    int          ia;
    int          ib;
    logic        ga;
    logic        gb;

    initial begin
        rr_we[0] = 16'h0002; rr_we[1] = 16'h0004; rr_we[2] = 16'h0002;
        ta_addr[0] = 4'h0; ta_addr[1] = 4'h9; ta_addr[2] = 4'hF;
        ta_addr[3] = 4'h9; ta_addr[4] = 4'h2; ta_addr[5] = 4'hC;
        tb_addr[0] = 4'h0; tb_addr[1] = 4'h4; tb_addr[2] = 4'hF;
        tb_addr[3] = 4'h9; tb_addr[4] = 4'h3; tb_addr[5] = 4'hE;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_we", we, 16'h0000);
        check("rst_wdata", wdata, 32'h0);
        check("rst_pc_write", pc_write, 1'b0);
        check("rst_conflict", conflict, 1'b0);
        cyc();
        reset_n = 1'b1;

        // Single requester
        cyc();
        set_a(1'b1, 4'h3, 32'hDEADBEEF);
        @(negedge clk);
        check("single_a_ready", a_ready, 1'b1);
        check("single_b_ready", b_ready, 1'b0);
        cyc();
        set_a(1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("single_we", we, 16'h0008);
        check("single_wdata", wdata, 32'hDEADBEEF);
        cyc();
        @(negedge clk);
        check("single_we_clear", we, 16'h0000);

        // Round-robin on ties
        cyc();
        set_a(1'b1, 4'h1, 32'h11);
        set_b(1'b1, 4'h2, 32'h22);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_a_ready", a_ready, (i % 2 == 0));
            if (i > 0) begin
                check("rr_we", we, rr_we[i-1]);
                check("rr_conflict", conflict, 1'b1);
            end
            cyc();
        end
        set_a(1'b0, 4'h0, 32'h0);
        set_b(1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("rr_we_last", we, 16'h0004);
        check("rr_conflict_last", conflict, 1'b1);

        // Move to PRI_B, then same-address ordering
        cyc();
        set_a(1'b1, 4'h4, 32'h44);
        set_b(1'b1, 4'h7, 32'h2);
        @(negedge clk);
        check("pre_sa_a_ready", a_ready, 1'b1);
        cyc();
        set_a(1'b1, 4'h7, 32'h1);
        @(negedge clk);
        check("sa_a_ready", a_ready, 1'b1);
        check("sa_b_ready", b_ready, 1'b0);
        check("sa_we_prev", we, 16'h0010);
        cyc();
        set_a(1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("sa_b_ready2", b_ready, 1'b1);
        check("sa_we_a", we, 16'h0080);
        check("sa_wdata_a", wdata, 32'h1);
        cyc();
        set_b(1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("sa_we_b", we, 16'h0080);
        check("sa_wdata_b", wdata, 32'h2);
        cyc();
        set_a(1'b1, 4'h1, 32'hA1);
        set_b(1'b1, 4'h2, 32'hB2);
        @(negedge clk);
        check("sa_state_held_b_ready", b_ready, 1'b1);
        cyc();
        set_b(1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("sa_tie_we", we, 16'h0004);
        check("sa_a_ready_after", a_ready, 1'b1);
        cyc();
        set_a(1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("sa_a_we", we, 16'h0002);

        // PC write
        cyc();
        set_b(1'b1, 4'hF, 32'h00000100);
        @(negedge clk);
        check("pc_b_ready", b_ready, 1'b1);
        cyc();
        set_b(1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("pc_we", we, 16'h8000);
        check("pc_wdata", wdata, 32'h00000100);
        check("pc_write_hi", pc_write, 1'b1);
        cyc();
        @(negedge clk);
        check("pc_write_lo", pc_write, 1'b0);

        // Asynchronous reset mid-cycle with both valid and a write in flight
        cyc();
        set_a(1'b1, 4'h3, 32'h33);
        set_b(1'b1, 4'h5, 32'h55);
        @(negedge clk);
        check("rm_a_ready", a_ready, 1'b1);
        @(posedge clk);
        #2;
        check("rm_we_before", we, 16'h0008);
        reset_n = 1'b0;
        #1;
        check("rm_we", we, 16'h0000);
        check("rm_pc_write", pc_write, 1'b0);
        check("rm_conflict", conflict, 1'b0);
        check("rm_a_ready_low", a_ready, 1'b0);
        check("rm_b_ready_low", b_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        check("rm_post_a_ready", a_ready, 1'b1);
        cyc();
        set_a(1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("rm_post_we", we, 16'h0008);
        check("rm_post_b_ready", b_ready, 1'b1);
        cyc();
        set_b(1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("rm_post_we_b", we, 16'h0020);

`ifdef WR_ARB_STALL_EN
        // Stall holds the PRI_B state
        cyc();
        stall = 1'b1;
        set_a(1'b1, 4'h1, 32'h1);
        set_b(1'b1, 4'h2, 32'h2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_a_ready", a_ready, 1'b0);
            check("stall_b_ready", b_ready, 1'b0);
            check("stall_we", we, 16'h0000);
            if (i > 0) check("stall_conflict", conflict, 1'b1);
            cyc();
        end
        stall = 1'b0;
        @(negedge clk);
        check("unstall_b_ready", b_ready, 1'b1);
        cyc();
        set_b(1'b0, 4'h0, 32'h0);
        @(negedge clk);
        check("unstall_we", we, 16'h0004);
        check("unstall_a_ready", a_ready, 1'b1);
        cyc();
        set_a(1'b0, 4'h0, 32'h0);
`endif

        // Handshake-respecting directed table, checked by the model
        ia = 0;
        ib = 0;
        cyc();
        for (int c = 0; c < 40 && (ia < 6 || ib < 6); c++) begin
            if (ia < 6) set_a(1'b1, ta_addr[ia], 32'hA000 + ia);
            else        set_a(1'b0, 4'h0, 32'h0);
            if (ib < 6) set_b(1'b1, tb_addr[ib], 32'hB000 + ib);
            else        set_b(1'b0, 4'h0, 32'h0);
            @(negedge clk);
            ga = a_ready;
            gb = b_ready;
            cyc();
            if (ga) ia++;
            if (gb) ib++;
        end
        set_a(1'b0, 4'h0, 32'h0);
        set_b(1'b0, 4'h0, 32'h0);
        check("table_drain", {ia[7:0], ib[7:0]}, {8'd6, 8'd6});
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
